reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised successor to the team's fixed 8x16 two-read/one-write register file.
- Generalised in data width and depth, with optional hardwired-zero r0 and a selectable read mode (combinational or registered).
- Adds a multi-cycle hardware clear sweep with a busy handshake and dropped-write reporting.
- Sits in the datapath between the decoder (addresses, write enable) and the ALU operand inputs.

Parameters:
- DATA_W, 16, width of each register and of d_in/d_out_a/d_out_b.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (derived, not overridable).
- REG_READ, 0, 0 = combinational (asynchronous) read ports; 1 = registered read ports with latency 1.
- ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are silently discarded.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- d_in  input  DATA_W  write data.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- d_out_a  output  DATA_W  read port A data.
- d_out_b  output  DATA_W  read port B data.
- clr_req  input  1  request a clear sweep of all registers.
- busy  output  1  high while the clear sweep is in progress.
- wr_drop  output  1  one-cycle pulse: a write was rejected because busy was high.

Behaviour:
- Reset (sync, active-high; clk and reset as named above):
  - On the edge where reset=1: all DEPTH entries <= 0, FSM <= IDLE, sweep pointer <= 0, busy <= 0, wr_drop <= 0.
  - If REG_READ=1, registered d_out_a/d_out_b <= 0.
  - Reset overrides wr and clr_req on the same edge.
  - Reset during SWEEP aborts the sweep; all state is zero on the next cycle.
- Write acceptance:
  - A write is accepted when wr=1 and busy=0: mem[wr_addr] <= d_in.
  - ZERO_REG=1 and wr_addr=0: write is accepted but discarded; wr_drop is not raised.
  - wr=1 with busy=1: write is discarded and wr_drop=1 on the following cycle only.
- Read, REG_READ=0:
  - d_out_x = mem[rd_addr_x] combinationally.
  - A value written at edge N is visible after edge N.
- Read, REG_READ=1:
  - d_out_x <= mem[rd_addr_x] at each edge; latency 1 cycle.
  - Reads sample pre-edge contents, subject to the bypass rules under Optional Feature.
- ZERO_REG=1: reads of address 0 return 0 in both modes, regardless of bypass.
- Both read ports are fully independent. rd_addr_a == rd_addr_b is legal and returns identical data.
- Clear FSM, states IDLE and SWEEP:
  - IDLE, clr_req=1 -> SWEEP; pointer <= 0; busy=1 from the next cycle.
  - SWEEP, each cycle: mem[pointer] <= 0; pointer <= pointer+1.
  - When pointer = DEPTH-1, that entry is cleared and the FSM -> IDLE; busy=0 on the next cycle.
  - busy is therefore high for exactly DEPTH cycles.
  - clr_req while in SWEEP is ignored; it does not restart or extend the sweep.
- Boundary cases:
  - clr_req and an accepted wr on the same edge in IDLE: the write lands, then the sweep clears it.
  - Reads during SWEEP return the current, partially cleared contents. Sweep clears are never bypassed.
  - Pointer wraps naturally at DEPTH. No out-of-range address exists.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined, REG_READ=0: if a write is accepted and wr_addr == rd_addr_x, d_out_x = d_in combinationally in the same cycle (write-through).
- Defined, REG_READ=1: if a write is accepted and wr_addr == rd_addr_x, d_out_x <= d_in at that edge (write-first).
- Not defined, either mode: read-first. The old value is returned in the write cycle; the new value appears from the next read onward.
- In all cases, bypass never applies to address 0 when ZERO_REG=1, to dropped writes, or to sweep clears.

Test Plan:
- Basic write/read (REG_READ=0, defaults): after reset, write 3<-16'hCDEF and 7<-16'h3210; set rd_addr_a=3, rd_addr_b=7 -> d_out_a=16'hCDEF, d_out_b=16'h3210. Unwritten address 5 reads 16'h0000.
- Registered read (REG_READ=1): write 5<-16'h4567; next cycle set rd_addr_a=5 -> d_out_a=16'h4567 one edge later, not in the same cycle.
- Bypass, RF_BYPASS_EN defined vs. undefined: reg 1=16'hBA98; write 1<-16'h1111 with rd_addr_a=1.
  - REG_READ=0 in the write cycle: d_out_a=16'h1111 if defined, 16'hBA98 if not.
  - REG_READ=1 after the write edge: d_out_a=16'h1111 if defined, 16'hBA98 if not.
- Clear sweep: fill all 8 regs with 16'hFFFF; pulse clr_req -> busy high exactly 8 cycles; wr to 2 during busy -> wr_drop pulses one cycle; afterwards all regs read 0.
- ZERO_REG=1: write 0<-16'hAAAA -> rd_addr_a=0 returns 16'h0000 (with bypass too); wr_drop stays 0.
- Reset mid-sweep: assert reset on the 4th busy cycle -> next cycle busy=0, all regs 0; a subsequent write 6<-16'h0F0F is accepted and reads back 16'h0F0F.

Source files
------------

// File: rtl/reg_file_param.sv
// ----------------------------------------------------------------------------
// reg_file_param
//   Parametrised two-read / one-write register file with an optional
//   hardwired-zero r0, selectable combinational or registered read ports, and
//   a multi-cycle clear sweep that reports writes dropped while it runs.
//
// Parameters
//   DATA_W    register / data width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   REG_READ  0 = combinational read, 1 = registered read (latency 1)
//   ZERO_REG  1 = register 0 reads 0, writes to it are discarded
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   wr, wr_addr, d_in   write port
//   rd_addr_a, d_out_a  read port A
//   rd_addr_b, d_out_b  read port B
//   clr_req             start a clear sweep (ignored while one is running)
//   busy                sweep in progress, writes are rejected
//   wr_drop             one-cycle pulse after a write rejected by busy
//
// Build option
//   RF_BYPASS_EN  defined: an accepted write to the address being read is
//                 forwarded to that read port (write-through / write-first).
//                 undefined: read-first.
//
// Clear FSM
//   state | meaning
//   IDLE  | normal operation, writes accepted
//   SWEEP | clearing mem[r_ptr] each cycle, writes dropped
// ----------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int REG_READ = 0,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_sweep_clr;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_drop;

    logic              w_busy;
    logic              w_wr_acc;
    logic              w_wr_store;

    logic              w_zero_a;
    logic              w_zero_b;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_busy   = (r_state == SWEEP);
    assign busy     = w_busy;
    assign wr_drop  = r_wr_drop;

    // An accepted write to r0 with ZERO_REG set is swallowed here, so it
    // neither updates the array nor feeds the bypass path.
    assign w_wr_acc   = wr && !w_busy;
    assign w_wr_store = w_wr_acc && !((ZERO_REG != 0) && (wr_addr == '0));

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sweep_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                w_sweep_clr = 1'b1;
                w_ptr_nxt   = r_ptr + ADDR_W'(1);
                if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. A store and a sweep clear never coincide: stores need
    // busy low, clears only happen in SWEEP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_store) begin
                r_mem[wr_addr] <= d_in;
            end
            if (w_sweep_clr) begin
                r_mem[r_ptr] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= wr && w_busy;
        end
    end

    // ------------------------------------------------------------------
    // Read data selection (shared by both read modes)
    // ------------------------------------------------------------------
    assign w_zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
    assign w_zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);
    assign w_byp_a  = BYPASS && w_wr_store && (wr_addr == rd_addr_a);
    assign w_byp_b  = BYPASS && w_wr_store && (wr_addr == rd_addr_b);

    assign w_rd_a = w_zero_a ? '0 : (w_byp_a ? d_in : r_mem[rd_addr_a]);
    assign w_rd_b = w_zero_b ? '0 : (w_byp_b ? d_in : r_mem[rd_addr_b]);

    generate
        if (REG_READ != 0) begin : g_reg_rd
            logic [DATA_W-1:0] r_dout_a;
            logic [DATA_W-1:0] r_dout_b;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dout_a <= '0;
                    r_dout_b <= '0;
                end else begin
                    r_dout_a <= w_rd_a;
                    r_dout_b <= w_rd_b;
                end
            end

            assign d_out_a = r_dout_a;
            assign d_out_b = r_dout_b;
        end else begin : g_comb_rd
            assign d_out_a = w_rd_a;
            assign d_out_b = w_rd_b;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    localparam int SEL_A       = 0;
    localparam int SEL_B       = 1;
    localparam int SEL_BUSY    = 2;
    localparam int SEL_DROP    = 3;
    localparam int SEL_RZ_A    = 4;
    localparam int SEL_RZ_B    = 5;
    localparam int SEL_RZ_BUSY = 6;
    localparam int SEL_RZ_DROP = 7;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic        clr_req;

    logic [15:0] d_out_a, d_out_b, rz_d_out_a, rz_d_out_b;
    logic        busy, wr_drop, rz_busy, rz_wr_drop;

    // default configuration: combinational read, no zero register
    reg_file_param u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .clr_req   (clr_req),
        .busy      (busy),
        .wr_drop   (wr_drop)
    );

    // registered read with hardwired-zero r0, same stimulus
    reg_file_param #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .REG_READ (1),
        .ZERO_REG (1)
    ) u_dut_rz (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (rz_d_out_a),
        .d_out_b   (rz_d_out_b),
        .clr_req   (clr_req),
        .busy      (rz_busy),
        .wr_drop   (rz_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            SEL_A:       return d_out_a;
            SEL_B:       return d_out_b;
            SEL_BUSY:    return {15'd0, busy};
            SEL_DROP:    return {15'd0, wr_drop};
            SEL_RZ_A:    return rz_d_out_a;
            SEL_RZ_B:    return rz_d_out_b;
            SEL_RZ_BUSY: return {15'd0, rz_busy};
            SEL_RZ_DROP: return {15'd0, rz_wr_drop};
            default:     return 16'hxxxx;
        endcase
    endfunction

    // monitor: every queued expectation is due in the cycle it was issued
    always @(negedge clk) begin
        logic [15:0] act;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = actual(e.sel);
            n_tests++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (issued cycle %0d, checked %0d)",
                         e.name, act, e.exp, e.cyc, cyc);
            end
        end
    end

    task automatic chk(input int sel, input logic [15:0] exp, input string name);
        exp_t x;
        x.cyc  = cyc;
        x.sel  = sel;
        x.exp  = exp;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr = 1'b0; wr_addr = '0; d_in = '0;
        rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        tick(); tick();

        // reset state
        reset = 1'b0; rd_addr_a = 3'd5; rd_addr_b = 3'd7;
        chk(SEL_A, 16'h0, "rst_a");
        chk(SEL_B, 16'h0, "rst_b");
        chk(SEL_BUSY, 16'h0, "rst_busy");
        chk(SEL_DROP, 16'h0, "rst_drop");
        chk(SEL_RZ_A, 16'h0, "rst_rz_a");
        chk(SEL_RZ_BUSY, 16'h0, "rst_rz_busy");
        tick();

        // basic write / read
        wr = 1'b1; wr_addr = 3'd3; d_in = 16'hCDEF; tick();
        wr_addr = 3'd7; d_in = 16'h3210; tick();
        wr = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        chk(SEL_A, 16'hCDEF, "rd_a_3");
        chk(SEL_B, 16'h3210, "rd_b_7");
        chk(SEL_RZ_A, 16'h0000, "rz_latency_a");
        tick();
        rd_addr_a = 3'd5;
        chk(SEL_A, 16'h0000, "unwritten_5");
        chk(SEL_RZ_A, 16'hCDEF, "rz_a_3");
        chk(SEL_RZ_B, 16'h3210, "rz_b_7");
        tick();
        rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        chk(SEL_A, 16'hCDEF, "same_addr_a");
        chk(SEL_B, 16'hCDEF, "same_addr_b");
        tick();

        // registered read latency
        wr = 1'b1; wr_addr = 3'd5; d_in = 16'h4567; rd_addr_a = 3'd3; tick();
        wr = 1'b0; rd_addr_a = 3'd5;
        chk(SEL_A, 16'h4567, "rd_a_5");
        chk(SEL_RZ_A, 16'hCDEF, "rz_not_same_cycle");
        tick();
        chk(SEL_RZ_A, 16'h4567, "rz_a_5");
        tick();

        // bypass behaviour
        wr = 1'b1; wr_addr = 3'd1; d_in = 16'hBA98; rd_addr_a = 3'd3; tick();
        d_in = 16'h1111; rd_addr_a = 3'd1;
        chk(SEL_A, BYP ? 16'h1111 : 16'hBA98, "byp_comb");
        tick();
        wr = 1'b0;
        chk(SEL_A, 16'h1111, "after_byp_a");
        chk(SEL_RZ_A, BYP ? 16'h1111 : 16'hBA98, "byp_reg");
        tick();

        // writes to r0: stored in default build, discarded with ZERO_REG
        wr = 1'b1; wr_addr = 3'd0; d_in = 16'hAAAA; rd_addr_a = 3'd0;
        chk(SEL_A, BYP ? 16'hAAAA : 16'h0000, "r0_write_cycle");
        tick();
        wr = 1'b0;
        chk(SEL_A, 16'hAAAA, "r0_plain_reg");
        chk(SEL_RZ_A, 16'h0000, "rz_zero_reg");
        chk(SEL_RZ_DROP, 16'h0, "rz_zero_no_drop");
        chk(SEL_DROP, 16'h0, "r0_no_drop");
        tick();

        // clear sweep
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; wr_addr = 3'(i); d_in = 16'hFFFF; tick();
        end
        wr = 1'b0; clr_req = 1'b1;
        chk(SEL_BUSY, 16'h0, "busy_before_sweep");
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr      = (k == 2);
            wr_addr = 3'd2;
            d_in    = 16'h1234;
            clr_req = (k == 3 || k == 5);
            chk(SEL_BUSY, 16'h1, $sformatf("busy_k%0d", k));
            chk(SEL_RZ_BUSY, 16'h1, $sformatf("rz_busy_k%0d", k));
            chk(SEL_DROP, (k == 3) ? 16'h1 : 16'h0, $sformatf("drop_k%0d", k));
            if (k == 0) begin
                rd_addr_a = 3'd7; rd_addr_b = 3'd0;
                chk(SEL_A, 16'hFFFF, "sweep_partial_7");
                chk(SEL_B, 16'hFFFF, "sweep_partial_0");
            end
            if (k == 1) begin
                chk(SEL_A, 16'hFFFF, "sweep_7_pending");
                chk(SEL_B, 16'h0000, "sweep_0_cleared");
            end
            tick();
        end
        wr = 1'b0; clr_req = 1'b0;
        chk(SEL_BUSY, 16'h0, "busy_end");
        chk(SEL_DROP, 16'h0, "drop_end");
        tick();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            chk(SEL_A, 16'h0, $sformatf("cleared_a%0d", i));
            chk(SEL_B, 16'h0, $sformatf("cleared_b%0d", 7 - i));
            tick();
        end

        // write with clr_req, then reset on 4th busy cycle
        wr = 1'b1; wr_addr = 3'd4; d_in = 16'h5555; clr_req = 1'b1;
        chk(SEL_BUSY, 16'h0, "busy_before_sweep2");
        tick();
        wr = 1'b0; clr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk(SEL_BUSY, 16'h1, $sformatf("busy2_k%0d", k));
            if (k == 0) begin
                rd_addr_a = 3'd4;
                chk(SEL_A, 16'h5555, "wr_with_clr_landed");
            end
            if (k == 3) reset = 1'b1;
            tick();
        end
        reset = 1'b0; rd_addr_a = 3'd4;
        chk(SEL_BUSY, 16'h0, "abort_busy");
        chk(SEL_RZ_BUSY, 16'h0, "abort_rz_busy");
        chk(SEL_A, 16'h0, "abort_clear_4");
        tick();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            chk(SEL_BUSY, 16'h0, $sformatf("abort_idle_%0d", i));
            chk(SEL_A, 16'h0, $sformatf("abort_zero_%0d", i));
            tick();
        end
        wr = 1'b1; wr_addr = 3'd6; d_in = 16'h0F0F; rd_addr_a = 3'd0; rd_addr_b = 3'd0; tick();
        wr = 1'b0; rd_addr_a = 3'd6; rd_addr_b = 3'd6;
        chk(SEL_A, 16'h0F0F, "post_reset_wr");
        chk(SEL_DROP, 16'h0, "post_reset_no_drop");
        tick();
        chk(SEL_RZ_A, 16'h0F0F, "rz_post_reset_wr");
        tick();
        tick();

        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
